mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_rr_pick.sv | 53 +++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared constants and helpers for the RAM-port arbiter slice:
//           default RAM geometry, requester index map and a ceil-log2
//           function used to size the round-robin pointer and tags.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 16;

  // Requester index map of the default three-port configuration
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_LOAD  = 2;

  // Ceil-log2, never below 1 so that a 2-requester pointer still has a bit
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_rr_pick.sv
// ============================================================================
// Module  : mem_rr_pick
// Purpose : Combinational round-robin picker. Searches the masked request
//           vector starting at i_ptr and wrapping modulo N.
// Ports   : i_req  - request vector
//           i_ptr  - search start index (0..N-1)
//           i_mask - eligibility mask (1 = may be granted)
//           o_gnt  - one-hot grant
//           o_idx  - index of the winner (0 when none)
//           o_vld  - a winner exists
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_vld
);

  logic [N-1:0] w_elig;

  assign w_elig = i_req & i_mask;

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Candidate index wraps modulo N without needing a power-of-two N
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_vld && w_elig[j]) begin
        o_vld    = 1'b1;
        o_idx    = PW'(j);
        o_gnt[j] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Purpose : Round-robin arbiter sharing one synchronous-read RAM port among
//           N_REQ requesters, with locked (atomic) sequences and a one-cycle
//           read-return strobe.
// Ports   : clk, rst_n           - clock, async active-low reset
//           req/we/lock          - per-requester command bits
//           addr/wdata           - flattened per-requester address / data
//           gnt                  - one-hot grant (transfer when req&gnt)
//           rvalid/rdata         - read-return strobe and data
//           ram_addr/ram_din/ram_we/ram_dout - RAM port
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_din,
  output logic                ram_we,
  input  logic [DW-1:0]       ram_dout
);

  localparam int PW = clog2(N_REQ);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic          r_owner_vld;
  logic          r_rd_pend;
  logic [PW-1:0] r_rd_tag;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;

  logic             w_hold;
  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_vld;
  logic             w_we;
  logic             w_lock;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_wdata;
  logic [PW-1:0]    w_ptr_nxt;

  // Ownership only restricts arbitration while the owner keeps requesting;
  // once it drops req, normal arbitration applies in that same cycle.
  assign w_hold = r_owner_vld & req[r_owner];

  always_comb begin
    w_mask = '1;
    if (w_hold) begin
      w_mask          = '0;
      w_mask[r_owner] = 1'b1;
    end
  end

  mem_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .i_mask (w_mask),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_vld  (w_vld)
  );

  always_comb begin
    w_we    = we[w_idx];
    w_lock  = lock[w_idx];
    w_addr  = addr[int'(w_idx)*AW +: AW];
    w_wdata = wdata[int'(w_idx)*DW +: DW];
  end

  assign w_ptr_nxt = (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + PW'(1);

  assign gnt      = w_gnt;
  assign ram_we   = w_vld & w_we;
  // Address/data hold their last granted values while the port is idle
  assign ram_addr = w_vld ? w_addr  : r_addr;
  assign ram_din  = w_vld ? w_wdata : r_din;
  // RAM output is already registered, so read data passes straight through
  assign rdata    = ram_dout;

  always_comb begin
    rvalid = '0;
    if (r_rd_pend) rvalid[r_rd_tag] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_tag    <= '0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      r_rd_pend <= w_vld & ~w_we;
      r_rd_tag  <= w_idx;
      if (w_vld) begin
        r_addr <= w_addr;
        r_din  <= w_wdata;
        if (w_lock) begin
          r_owner_vld <= 1'b1;
          r_owner     <= w_idx;
        end else begin
          r_owner_vld <= 1'b0;
          r_ptr       <= w_ptr_nxt;
        end
      end else begin
        // No winner means the owner (if any) has stopped requesting
        r_owner_vld <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
